fish_sprite_renderer: RTL and testbench
=======================================

Name: fish_sprite_renderer

Overview:
Upstream address generator and downstream compositor for the fish sprite block RAM (sync read, 1-cycle latency, 12-bit RGB words).
- Tracks fish position and swim direction, advancing once per video frame.
- Cycles animation frames stored back-to-back in the sprite RAM.
- Converts VGA pixel coordinates into sprite RAM addresses, then merges the returned texel over the background with colour-key transparency.

Parameters:
FISH_W, 64, sprite width in pixels
FISH_H, 32, sprite height in pixels
FISH_FRAMES, 4, animation frames stored consecutively (frame f base = f*FISH_W*FISH_H)
SCREEN_W, 320, visible width in pixels
ADDR_WIDTH, 16, sprite RAM address width
DATA_WIDTH, 12, RGB word width
TRANSP, 12'h0F0, transparent colour key
FRAME_DIV, 4, frame_ticks per animation step
SPEED, 1, pixels moved per frame_tick

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
pixel_x  in  10  current pixel column
pixel_y  in  10  current pixel row
pixel_tick  in  1  pixel_x/pixel_y valid this cycle
frame_tick  in  1  one-cycle pulse, start of vblank
fish_y_base  in  10  sprite top row (static per frame)
bg_rgb  in  DATA_WIDTH  background pixel aligned with pixel_x/pixel_y
sram_addr  out  ADDR_WIDTH  sprite RAM address (registered)
sram_en  out  1  sprite RAM read enable (registered)
sram_data  in  DATA_WIDTH  sprite RAM read data
rgb_o  out  DATA_WIDTH  composited pixel
rgb_valid  out  1  rgb_o valid

Behaviour:
- Reset (reset_n=0 at clk edge): fish_x=0, dir=SWIM_RIGHT, anim_idx=0, div_cnt=0, sram_addr=0, sram_en=0, rgb_o=0, rgb_valid=0. All pipeline valid bits clear, so a mid-operation reset flushes in-flight pixels.
- Motion FSM {SWIM_RIGHT, SWIM_LEFT}, evaluated only on frame_tick:
  - RIGHT: if fish_x+SPEED >= SCREEN_W-FISH_W, then fish_x=SCREEN_W-FISH_W and dir becomes LEFT; else fish_x += SPEED.
  - LEFT: if fish_x <= SPEED, then fish_x=0 and dir becomes RIGHT; else fish_x -= SPEED.
- Animation: div_cnt counts frame_ticks 0..FRAME_DIV-1. On wrap, anim_idx = (anim_idx+1) mod FISH_FRAMES.
- Region: in_reg = fish_x <= pixel_x < fish_x+FISH_W and fish_y_base <= pixel_y < fish_y_base+FISH_H. Compares are done at 11 bits to avoid overflow.
- Address: row = pixel_y-fish_y_base; col = pixel_x-fish_x. addr = anim_idx*FISH_W*FISH_H + row*FISH_W + col, truncated to ADDR_WIDTH.
- Pipeline (pixel_tick sampled at edge t):
  - Edge t: register sram_addr; sram_en = in_reg; stage-1 valid; bg_rgb.
  - Edge t+1: RAM returns sram_data; stage-2 regs shift.
  - Edge t+2: rgb_o = (in_reg_d2 && sram_data != TRANSP) ? sram_data : bg_d2; rgb_valid = valid_d2.
  - Latency is 2 edges after sampling; back-to-back pixel_tick is supported at throughput 1/cycle.
- Outside the region: sram_en=0, sram_addr holds its last value, rgb_o = background.
- pixel_tick=0: no sram_en, and rgb_valid=0 two edges later; rgb_o holds.
- frame_tick coincident with pixel_tick: region/address use pre-update fish_x/anim_idx/dir.

Optional Feature:
FISH_MIRROR_EN:
- Defined: when dir=SWIM_LEFT, col = FISH_W-1-(pixel_x-fish_x), so the sprite faces its swim direction.
- Undefined: col is never mirrored; the mirror logic is absent.

Decomposition:
- Package fish_pkg: dir enum {SWIM_RIGHT, SWIM_LEFT}, TRANSP, SCREEN_W/SCREEN_H, FISH_W/FISH_H, and localparam FRAME_WORDS = FISH_W*FISH_H.
- Sub-module fish_motion_ctrl: position FSM plus animation divider. Inputs clk, reset_n, frame_tick; outputs fish_x, dir, anim_idx.
- Top level holds region check, address math, pipeline and compositing.

Test Plan:
1. Reset hold 3 cycles, then release -> rgb_valid=0, sram_en=0, rgb_o=0, fish_x=0, dir=RIGHT.
2. fish_y_base=10, pixel (5,12) with pixel_tick -> sram_addr=133, sram_en=1 after edge t; RAM model returns 12'hABC -> rgb_o=12'hABC, rgb_valid=1 at edge t+2.
3. Transparency: sram_data=12'h0F0, bg_rgb=12'h123 -> rgb_o=12'h123. Pixel (100,100) -> sram_en=0, rgb_o=bg_rgb.
4. Bounce: 256 frame_ticks -> fish_x=256, dir=LEFT; 257th -> fish_x=255; drive back to 0 -> dir=RIGHT.
5. Animation: 4 frame_ticks -> anim_idx=1 and fish_x=4; pixel (4,10) -> sram_addr=2048. After 16 ticks anim_idx wraps to 0.
6. FISH_MIRROR_EN, dir=LEFT, fish_x=200, anim_idx=0, pixel (200,10) -> sram_addr=63; without the macro -> sram_addr=0.

Source files
------------

// File: rtl/fish_pkg.sv
// Shared types and constants for the fish sprite renderer.
// Contents: swim direction enum (also the motion FSM state), sprite and
// screen geometry, RAM word/address widths, the transparent colour key and
// the motion/animation rates.
package fish_pkg;

  localparam int FISH_W      = 64;
  localparam int FISH_H      = 32;
  localparam int FISH_FRAMES = 4;
  localparam int SCREEN_W    = 320;
  localparam int SCREEN_H    = 240;
  localparam int ADDR_WIDTH  = 16;
  localparam int DATA_WIDTH  = 12;
  localparam int FRAME_DIV   = 4;
  localparam int SPEED       = 1;
  localparam int COORD_W     = 10;

  localparam logic [DATA_WIDTH-1:0] TRANSP = 12'h0F0;

  // Words per animation frame; frame f starts at f*FRAME_WORDS.
  localparam int FRAME_WORDS = FISH_W * FISH_H;
  // Rightmost legal fish_x (sprite flush with the right screen edge).
  localparam int X_MAX       = SCREEN_W - FISH_W;
  localparam int ANIM_W      = $clog2(FISH_FRAMES);
  localparam int DIV_W       = $clog2(FRAME_DIV);

  typedef enum logic {
    SWIM_RIGHT = 1'b0,
    SWIM_LEFT  = 1'b1
  } dir_e;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/fish_motion_ctrl.sv
// Fish position/direction FSM plus the animation frame divider.
// Everything advances only on frame_tick.
// Ports:
//   clk, reset_n    clock, synchronous active-low reset
//   frame_tick      one-cycle pulse per video frame
//   fish_x          sprite left column
//   dir             swim direction (this is the FSM state)
//   anim_idx        current animation frame
module fish_motion_ctrl
  import fish_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  output logic [COORD_W-1:0] fish_x,
  output dir_e               dir,
  output logic [ANIM_W-1:0]  anim_idx
);

  dir_e               dir_q, dir_d;
  logic [COORD_W-1:0] fish_x_q, fish_x_d;
  logic [ANIM_W-1:0]  anim_q, anim_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [COORD_W:0]   x_plus;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dir_q    <= SWIM_RIGHT;
      fish_x_q <= '0;
      anim_q   <= '0;
      div_q    <= '0;
    end else begin
      dir_q    <= dir_d;
      fish_x_q <= fish_x_d;
      anim_q   <= anim_d;
      div_q    <= div_d;
    end
  end

  always_comb begin
    dir_d    = dir_q;
    fish_x_d = fish_x_q;
    anim_d   = anim_q;
    div_d    = div_q;
    // One extra bit so the right-edge compare cannot wrap.
    x_plus   = {1'b0, fish_x_q} + (COORD_W+1)'(SPEED);
    if (frame_tick) begin
      case (dir_q)
        SWIM_RIGHT: begin
          if (x_plus >= (COORD_W+1)'(X_MAX)) begin
            fish_x_d = COORD_W'(X_MAX);
            dir_d    = SWIM_LEFT;
          end else begin
            fish_x_d = x_plus[COORD_W-1:0];
          end
        end
        SWIM_LEFT: begin
          if (fish_x_q <= COORD_W'(SPEED)) begin
            fish_x_d = '0;
            dir_d    = SWIM_RIGHT;
          end else begin
            fish_x_d = fish_x_q - COORD_W'(SPEED);
          end
        end
        default: dir_d = SWIM_RIGHT;
      endcase
      if (div_q == DIV_W'(FRAME_DIV-1)) begin
        div_d  = '0;
        anim_d = (anim_q == ANIM_W'(FISH_FRAMES-1)) ? '0 : anim_q + 1'b1;
      end else begin
        div_d  = div_q + 1'b1;
      end
    end
  end

  assign fish_x   = fish_x_q;
  assign dir      = dir_q;
  assign anim_idx = anim_q;

endmodule

// File: rtl/fish_sprite_renderer.sv
// Fish sprite renderer: turns VGA pixel coordinates into sprite RAM
// addresses and composites the returned texel over the background using a
// colour key. The sprite RAM is external, sync read, 1-cycle latency.
// Optional build macro: FISH_MIRROR_EN -- mirror columns while swimming left.
// Handshake: pixel_tick is a valid-only strobe with no back-pressure; one
// pixel may be accepted every cycle and its result appears with rgb_valid
// two edges after the edge that sampled pixel_tick.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   pixel_x, pixel_y      current pixel, qualified by pixel_tick
//   frame_tick            start-of-vblank pulse, advances motion/animation
//   fish_y_base           sprite top row
//   bg_rgb                background pixel aligned with pixel_x/pixel_y
//   sram_addr, sram_en    registered sprite RAM read request
//   sram_data             sprite RAM read data
//   rgb_o, rgb_valid      composited pixel and its valid
module fish_sprite_renderer
  import fish_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [COORD_W-1:0]    pixel_x,
  input  logic [COORD_W-1:0]    pixel_y,
  input  logic                  pixel_tick,
  input  logic                  frame_tick,
  input  logic [COORD_W-1:0]    fish_y_base,
  input  logic [DATA_WIDTH-1:0] bg_rgb,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_en,
  input  logic [DATA_WIDTH-1:0] sram_data,
  output logic [DATA_WIDTH-1:0] rgb_o,
  output logic                  rgb_valid
);

  logic [COORD_W-1:0] fish_x;
  dir_e               dir;
  logic [ANIM_W-1:0]  anim_idx;

  fish_motion_ctrl u_motion (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .fish_x     (fish_x),
    .dir        (dir),
    .anim_idx   (anim_idx)
  );

  // Region test at 11 bits so fish_x+FISH_W cannot wrap.
  logic [COORD_W:0]   px_w, py_w, fx_w, fy_w;
  logic               in_reg;
  logic [COORD_W-1:0] row, col, col_eff;
  addr_t              addr;

  always_comb begin
    px_w   = {1'b0, pixel_x};
    py_w   = {1'b0, pixel_y};
    fx_w   = {1'b0, fish_x};
    fy_w   = {1'b0, fish_y_base};
    in_reg = (px_w >= fx_w) && (px_w < fx_w + (COORD_W+1)'(FISH_W)) &&
             (py_w >= fy_w) && (py_w < fy_w + (COORD_W+1)'(FISH_H));
    row    = pixel_y - fish_y_base;
    col    = pixel_x - fish_x;
  end

`ifdef FISH_MIRROR_EN
  assign col_eff = (dir == SWIM_LEFT) ? COORD_W'(FISH_W-1) - col : col;
`else
  assign col_eff = col;
  logic unused_dir;
  assign unused_dir = dir;
`endif

  // Only meaningful when in_reg; out-of-range row/col just wrap harmlessly.
  assign addr = addr_t'(anim_idx) * addr_t'(FRAME_WORDS) +
                addr_t'(row) * addr_t'(FISH_W) + addr_t'(col_eff);

  // Stage 1: RAM request; stage 2: waits for RAM data; then composite.
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic                  sram_en_q, sram_en_d;
  logic                  v1_q, v1_d, v2_q, v2_d;
  logic                  in1_q, in1_d, in2_q, in2_d;
  logic [DATA_WIDTH-1:0] bg1_q, bg1_d, bg2_q, bg2_d;
  logic [DATA_WIDTH-1:0] rgb_q, rgb_d;
  logic                  rgb_valid_q, rgb_valid_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sram_addr_q <= '0;
      sram_en_q   <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      in1_q       <= 1'b0;
      in2_q       <= 1'b0;
      bg1_q       <= '0;
      bg2_q       <= '0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      sram_addr_q <= sram_addr_d;
      sram_en_q   <= sram_en_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      bg1_q       <= bg1_d;
      bg2_q       <= bg2_d;
      rgb_q       <= rgb_d;
      rgb_valid_q <= rgb_valid_d;
    end
  end

  always_comb begin
    sram_en_d   = pixel_tick && in_reg;
    // Address holds outside the sprite so the RAM bus stays quiet.
    sram_addr_d = sram_en_d ? addr : sram_addr_q;
    v1_d        = pixel_tick;
    in1_d       = pixel_tick && in_reg;
    bg1_d       = bg_rgb;
    v2_d        = v1_q;
    in2_d       = in1_q;
    bg2_d       = bg1_q;
    rgb_valid_d = v2_q;
    rgb_d       = rgb_q;
    if (v2_q) begin
      rgb_d = (in2_q && (sram_data != TRANSP)) ? sram_data : bg2_q;
    end
  end

  assign sram_addr = sram_addr_q;
  assign sram_en   = sram_en_q;
  assign rgb_o     = rgb_q;
  assign rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_fish_sprite_renderer.sv
// Bench for fish_sprite_renderer: sync-read sprite RAM model, behavioural
// fish model, expected queues filled by the driver and drained by a monitor.
module tb_fish_sprite_renderer;
  import fish_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [9:0]            pixel_x = '0, pixel_y = '0, fish_y_base = '0;
  logic                  pixel_tick = 1'b0, frame_tick = 1'b0;
  logic [11:0]           bg_rgb = '0;
  logic [15:0]           sram_addr;
  logic                  sram_en;
  logic [11:0]           sram_data = '0;
  logic [11:0]           rgb_o;
  logic                  rgb_valid;

  fish_sprite_renderer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_tick  (pixel_tick),
    .frame_tick  (frame_tick),
    .fish_y_base (fish_y_base),
    .bg_rgb      (bg_rgb),
    .sram_addr   (sram_addr),
    .sram_en     (sram_en),
    .sram_data   (sram_data),
    .rgb_o       (rgb_o),
    .rgb_valid   (rgb_valid)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- sprite RAM model ----------------
  logic [11:0] mem [0:65535];
  always @(posedge clk) if (sram_en) sram_data <= mem[sram_addr];

  // ---------------- reference model ----------------
  int m_x, m_left, m_anim, m_div;

  task automatic model_reset();
    m_x = 0; m_left = 0; m_anim = 0; m_div = 0;
  endtask

  task automatic model_frame();
    if (!m_left) begin
      if (m_x + SPEED >= SCREEN_W - FISH_W) begin m_x = SCREEN_W - FISH_W; m_left = 1; end
      else m_x = m_x + SPEED;
    end else begin
      if (m_x <= SPEED) begin m_x = 0; m_left = 0; end
      else m_x = m_x - SPEED;
    end
    m_div = m_div + 1;
    if (m_div == FRAME_DIV) begin m_div = 0; m_anim = (m_anim + 1) % FISH_FRAMES; end
  endtask

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  logic [16:0] exp_a_q[$];
  int n_checks = 0, n_err = 0;
  bit mon_en = 1'b0;
  logic pix_prev = 1'b0;
  logic [15:0] last_addr = '0;
  logic [11:0] last_rgb = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  always @(posedge clk) pix_prev <= reset_n && pixel_tick;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pix_prev) begin
        if (exp_a_q.size() == 0) chk("addr_queue_empty", 1, 0);
        else begin
          logic [16:0] a;
          a = exp_a_q.pop_front();
          chk("sram_en", 32'(sram_en), 32'(a[16]));
          if (a[16]) begin
            chk("sram_addr", 32'(sram_addr), 32'(a[15:0]));
            last_addr = a[15:0];
          end else chk("sram_addr_hold", 32'(sram_addr), 32'(last_addr));
        end
      end else chk("sram_en_idle", 32'(sram_en), 0);
      if (rgb_valid) begin
        if (exp_q.size() == 0) chk("rgb_unexpected_valid", 1, 0);
        else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          chk("rgb_o", 32'(rgb_o), 32'(e));
          last_rgb = e;
        end
      end else chk("rgb_hold", 32'(rgb_o), 32'(last_rgb));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int px, input int py, input bit pt, input bit ft, input logic [11:0] bg);
    int inr, col, addr;
    logic [11:0] w;
    pixel_x = 10'(px); pixel_y = 10'(py); pixel_tick = pt; frame_tick = ft; bg_rgb = bg;
    if (pt) begin
      inr = (px >= m_x && px < m_x + FISH_W && py >= int'(fish_y_base) &&
             py < int'(fish_y_base) + FISH_H) ? 1 : 0;
      col = px - m_x;
`ifdef FISH_MIRROR_EN
      if (m_left != 0) col = FISH_W - 1 - col;
`endif
      addr = (m_anim * FRAME_WORDS + (py - int'(fish_y_base)) * FISH_W + col) & 32'hFFFF;
      w = mem[addr];
      exp_a_q.push_back({inr[0], addr[15:0]});
      exp_q.push_back((inr != 0 && w != TRANSP) ? w : bg);
    end
    if (ft) model_frame();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 12'h000);
  endtask

  task automatic rand_step(input bit ft);
    int px, py;
    if ($urandom_range(0, 1) == 1) begin
      px = m_x + $urandom_range(0, 80) - 8;
      py = int'(fish_y_base) + $urandom_range(0, 40) - 4;
      if (px < 0) px = 0;
      if (py < 0) py = 0;
    end else begin
      px = $urandom_range(0, 639);
      py = $urandom_range(0, 479);
    end
    step(px, py, ($urandom_range(0, 3) != 0), ft, 12'($urandom_range(0, 4095)));
  endtask

  task automatic do_reset(input int n, input bit noisy);
    mon_en = 1'b0;
    reset_n = 1'b0;
    frame_tick = 1'b0;
    exp_q.delete();
    exp_a_q.delete();
    for (int i = 0; i < n; i++) begin
      pixel_tick = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      pixel_x = 10'($urandom_range(0, 63));
      pixel_y = fish_y_base;
      @(posedge clk); #1;
    end
    pixel_tick = 1'b0;
    chk("reset_rgb_valid", 32'(rgb_valid), 0);
    chk("reset_sram_en", 32'(sram_en), 0);
    chk("reset_rgb_o", 32'(rgb_o), 0);
    chk("reset_sram_addr", 32'(sram_addr), 0);
    chk("reset_fish_x", 32'(dut.fish_x), 0);
    chk("reset_dir", 32'(dut.dir), 32'(SWIM_RIGHT));
    chk("reset_anim", 32'(dut.anim_idx), 0);
    model_reset();
    last_addr = '0;
    last_rgb = '0;
    reset_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic chk_motion(input string nm);
    chk({nm, "_fish_x"}, 32'(dut.fish_x), 32'(m_x));
    chk({nm, "_dir"}, 32'(dut.dir), 32'(m_left));
    chk({nm, "_anim"}, 32'(dut.anim_idx), 32'(m_anim));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 65536; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? TRANSP : 12'($urandom_range(0, 4095));
    mem[133] = 12'hABC;
    mem[134] = TRANSP;
    model_reset();
    @(posedge clk); #1;
    do_reset(3, 1'b0);

    // Basic fetch, transparency, outside region, back-to-back.
    fish_y_base = 10'd10;
    step(5, 12, 1, 0, 12'h555);
    step(6, 12, 1, 0, 12'h123);
    step(100, 100, 1, 0, 12'h321);
    idle(2);
    step(0, 10, 1, 0, 12'h001);
    step(63, 41, 1, 0, 12'h002);
    step(64, 41, 1, 0, 12'h003);
    step(63, 42, 1, 0, 12'h004);
    idle(3);

    // Animation: 4 ticks -> frame 1, then wrap after 16.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 12'h0);
    chk_motion("anim4");
    step(4, 10, 1, 0, 12'h0AA);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 12'h0);
    chk_motion("anim16");
    step(20, 15, 1, 0, 12'h0BB);
    idle(3);

    // Bounce with pixel traffic mixed in.
    do_reset(2, 1'b0);
    fish_y_base = 10'd10;
    for (int i = 0; i < 256; i++) begin
      rand_step(1'b0);
      step(m_x + 3, 12, 1, 1, 12'h0CC);
    end
    chk_motion("bounce256");
    step(0, 0, 0, 1, 12'h0);
    chk_motion("bounce257");
    for (int i = 0; i < 56; i++) step(0, 0, 0, 1, 12'h0);
    step(200, 10, 1, 0, 12'h0DD);
    step(263, 41, 1, 0, 12'h0DE);
    for (int i = 0; i < 199; i++) step(201 - i, 11, 1, 1, 12'h0EE);
    chk_motion("bounce_left_edge");
    step(0, 0, 0, 1, 12'h0);
    chk_motion("bounce_back_right");
    idle(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) fish_y_base = 10'($urandom_range(0, 220));
      rand_step($urandom_range(0, 19) == 0);
    end
    chk_motion("random_end");

    // Mid-stream reset must flush in-flight pixels.
    step(m_x + 1, int'(fish_y_base) + 1, 1, 0, 12'h111);
    step(m_x + 2, int'(fish_y_base) + 1, 1, 0, 12'h222);
    do_reset(2, 1'b1);
    idle(6);
    for (int i = 0; i < 40; i++) rand_step(1'b0);

    idle(3);
    for (int i = 0; i < 20 && (exp_q.size() != 0 || exp_a_q.size() != 0); i++) idle(1);
    chk("drain_rgb_queue", 32'(exp_q.size()), 0);
    chk("drain_addr_queue", 32'(exp_a_q.size()), 0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
